// File: rtl/ccx_arbiter_if.sv
// CCX port bundle: fetch requester, data requester and the downstream bridge port.
// master is the arbiter's view; slave is the view of the requesters plus bridge.
interface ccx_arbiter_if #(
    parameter int AW = 39,
    parameter int DW = 64
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_err;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_wen;
    logic [7:0]    d_strb;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_err;
    logic [DW-1:0] d_rdata;

    logic          m_req;
    logic          m_rtype;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [7:0]    m_strb;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_err;
    logic [DW-1:0] m_rdata;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_addr, d_wen, d_strb, d_wdata,
        input  m_gnt, m_err, m_rdata,
        output i_gnt, i_err, i_rdata,
        output d_gnt, d_err, d_rdata,
        output m_req, m_rtype, m_addr, m_wen, m_strb, m_wdata
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_addr, d_wen, d_strb, d_wdata,
        output m_gnt, m_err, m_rdata,
        input  i_gnt, i_err, i_rdata,
        input  d_gnt, d_err, d_rdata,
        input  m_req, m_rtype, m_addr, m_wen, m_strb, m_wdata
    );
endinterface

// File: rtl/ccx_arbiter.sv
// Two-requester arbiter for the CCX memory port: data wins by default, a saturating
// starvation counter forces fetch through after STARVE_LIMIT data wins in a row.
module ccx_arbiter #(
    parameter int          AW           = 39,
    parameter int          DW           = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           axi_aclk,
    input  logic           axi_aresetn,
    ccx_arbiter_if.master  bus
);
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam bit         STARVE_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ctr_q, ctr_d;
    logic       req_q, rtype_q;

    // Requests are only looked at in IDLE; the owner is locked until its m_gnt.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req && (!bus.d_req || (STARVE_EN && ctr_q == LIMIT))) begin
                    state_d = BUSY_I;
                    ctr_d   = '0;
                end else if (bus.d_req) begin
                    state_d = BUSY_D;
                    if (bus.i_req && ctr_q != LIMIT) ctr_d = ctr_q + 4'd1;
                end
            end
            BUSY_I, BUSY_D: if (bus.m_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // m_req/m_rtype come straight from flops so no request input reaches them combinationally.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            req_q   <= 1'b0;
            rtype_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            req_q   <= (state_d != IDLE);
            rtype_q <= (state_d == BUSY_D);
        end
    end

    assign bus.m_req   = req_q;
    assign bus.m_rtype = rtype_q;

    always_comb begin
        bus.m_addr  = '0;
        bus.m_wen   = 1'b0;
        bus.m_strb  = '0;
        bus.m_wdata = '0;
        case (state_q)
            BUSY_I: bus.m_addr = bus.i_addr;
            BUSY_D: begin
                bus.m_addr  = bus.d_addr;
                bus.m_wen   = bus.d_wen;
                bus.m_strb  = bus.d_strb;
                bus.m_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    // A stray m_gnt in IDLE routes nowhere.
    assign bus.i_gnt   = bus.m_gnt && (state_q == BUSY_I);
    assign bus.d_gnt   = bus.m_gnt && (state_q == BUSY_D);

    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;
    assign bus.i_err   = bus.m_err;
    assign bus.d_err   = bus.m_err;
endmodule

// File: tb/tb_ccx_arbiter.sv
// Directed bench for ccx_arbiter: one instance with STARVE_LIMIT=4, one with strict data priority.
module tb_ccx_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    ccx_arbiter_if #(.AW(39), .DW(64)) bus  ();
    ccx_arbiter_if #(.AW(39), .DW(64)) bus0 ();

    ccx_arbiter #(.AW(39), .DW(64), .STARVE_LIMIT(4)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus)
    );

    ccx_arbiter #(.AW(39), .DW(64), .STARVE_LIMIT(0)) dut0 (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_gnt(input bit z, input logic v);
        if (z) bus0.m_gnt = v;
        else   bus.m_gnt  = v;
    endtask

    // Called in an IDLE arbitration cycle with requests already driven; one 2-cycle bridge
    // response, and returns in the IDLE bubble after it.
    task automatic run_txn(input bit z, input logic exp_d, input string tag);
        tick();
        chk({tag, " m_req"}, z ? bus0.m_req : bus.m_req, 1);
        chk({tag, " rtype"}, z ? bus0.m_rtype : bus.m_rtype, exp_d);
        tick();
        set_gnt(z, 1'b1);
        #1;
        chk({tag, " d_gnt"}, z ? bus0.d_gnt : bus.d_gnt, exp_d);
        chk({tag, " i_gnt"}, z ? bus0.i_gnt : bus.i_gnt, !exp_d);
        tick();
        set_gnt(z, 1'b0);
        #1;
        chk({tag, " gap"}, z ? bus0.m_req : bus.m_req, 0);
    endtask

    logic [9:0] ord;

    initial begin
        clk = 0;
        rst_n = 0;
        {bus.i_req, bus.d_req, bus.d_wen, bus.m_gnt, bus.m_err} = '0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_strb = '0; bus.d_wdata = '0; bus.m_rdata = '0;
        {bus0.i_req, bus0.d_req, bus0.d_wen, bus0.m_gnt, bus0.m_err} = '0;
        bus0.i_addr = '0; bus0.d_addr = '0; bus0.d_strb = '0; bus0.d_wdata = '0; bus0.m_rdata = '0;

        // reset values, with a stray m_gnt that must not leak through
        #2;
        bus.m_gnt = 1'b1;
        #1;
        chk("rst m_req", bus.m_req, 0);
        chk("rst m_rtype", bus.m_rtype, 0);
        chk("rst i_gnt", bus.i_gnt, 0);
        chk("rst d_gnt", bus.d_gnt, 0);
        chk("rst0 m_req", bus0.m_req, 0);
        bus.m_gnt = 1'b0;
        tick();
        tick();
        rst_n = 1;

        // 1: lone fetch, m_gnt at cycle 3, read data at cycle 4
        bus.i_req = 1; bus.i_addr = 39'h1000; bus.d_wdata = 64'h55; bus.d_strb = 8'hFF; bus.d_wen = 1;
        #1;
        chk("t1 c0 m_req", bus.m_req, 0);
        tick();
        chk("t1 c1 m_req", bus.m_req, 1);
        chk("t1 c1 rtype", bus.m_rtype, 0);
        chk("t1 c1 wen", bus.m_wen, 0);
        chk("t1 c1 addr", bus.m_addr, 64'h1000);
        chk("t1 c1 wdata", bus.m_wdata, 0);
        chk("t1 c1 strb", bus.m_strb, 0);
        tick();
        chk("t1 c2 m_req", bus.m_req, 1);
        chk("t1 c2 i_gnt", bus.i_gnt, 0);
        tick();
        bus.m_gnt = 1;
        #1;
        chk("t1 c3 i_gnt", bus.i_gnt, 1);
        chk("t1 c3 d_gnt", bus.d_gnt, 0);
        tick();
        bus.m_gnt = 0; bus.i_req = 0; bus.m_rdata = 64'h0123_4567_89AB_CDEF; bus.m_err = 0;
        #1;
        chk("t1 c4 i_gnt", bus.i_gnt, 0);
        chk("t1 c4 i_rdata", bus.i_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t1 c4 i_err", bus.i_err, 0);
        chk("t1 c4 m_req", bus.m_req, 0);
        bus.d_wen = 0; bus.d_strb = 0; bus.d_wdata = 0;

        // 2: both held, grant order D,D,D,D,I,D,D,D,D,I (bit k = grant k, 1 = data)
        ord = 10'b0111101111;
        bus.i_req = 1; bus.d_req = 1; bus.d_addr = 39'h4000;
        for (int k = 0; k < 10; k++) run_txn(1'b0, ord[k], $sformatf("t2 txn%0d", k));
        bus.i_req = 0; bus.d_req = 0;
        tick();

        // 4: write, requester drops d_req mid-transaction
        bus.d_req = 1; bus.d_wen = 1; bus.d_strb = 8'h0F; bus.d_wdata = 64'hDEADBEEF; bus.d_addr = 39'h2000;
        tick();
        chk("t4 m_req", bus.m_req, 1);
        chk("t4 rtype", bus.m_rtype, 1);
        chk("t4 wen", bus.m_wen, 1);
        chk("t4 strb", bus.m_strb, 8'h0F);
        chk("t4 wdata", bus.m_wdata, 64'hDEADBEEF);
        chk("t4 addr", bus.m_addr, 64'h2000);
        bus.d_req = 0;
        tick();
        chk("t4 held m_req", bus.m_req, 1);
        chk("t4 held wdata", bus.m_wdata, 64'hDEADBEEF);
        chk("t4 held strb", bus.m_strb, 8'h0F);
        tick();
        bus.m_gnt = 1;
        #1;
        chk("t4 d_gnt", bus.d_gnt, 1);
        chk("t4 i_gnt", bus.i_gnt, 0);
        tick();
        bus.m_gnt = 0;
        #1;
        chk("t4 idle m_req", bus.m_req, 0);
        chk("t4 idle d_gnt", bus.d_gnt, 0);
        bus.d_wen = 0; bus.d_strb = 0; bus.d_wdata = 0;

        // 5a: reset during BUSY_I, pending data wins afterwards
        bus.i_req = 1;
        tick();
        chk("t5 busy_i m_req", bus.m_req, 1);
        chk("t5 busy_i rtype", bus.m_rtype, 0);
        bus.d_req = 1;
        tick();
        rst_n = 0;
        #1;
        chk("t5 async m_req", bus.m_req, 0);
        chk("t5 async rtype", bus.m_rtype, 0);
        tick();
        rst_n = 1;
        run_txn(1'b0, 1'b1, "t5 first");
        run_txn(1'b0, 1'b1, "t5 second");
        // 5b: starve counter is mid-count here; reset during BUSY_D must restart the count
        tick();
        chk("t5b busy_d rtype", bus.m_rtype, 1);
        rst_n = 0;
        #1;
        chk("t5b async m_req", bus.m_req, 0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 5; k++) run_txn(1'b0, (k != 4), $sformatf("t5b txn%0d", k));
        bus.i_req = 0; bus.d_req = 0;

        // 3: strict data priority, fetch only gets in once d_req drops in IDLE
        bus0.i_req = 1; bus0.d_req = 1; bus0.i_addr = 39'h8000;
        for (int k = 0; k < 6; k++) run_txn(1'b1, 1'b1, $sformatf("t3 txn%0d", k));
        bus0.d_req = 0;
        run_txn(1'b1, 1'b0, "t3 fetch");
        bus0.i_req = 0;

        // 6: stray m_gnt in IDLE, then a data read that returns an error
        tick();
        bus.m_gnt = 1;
        #1;
        chk("t6 idle i_gnt", bus.i_gnt, 0);
        chk("t6 idle d_gnt", bus.d_gnt, 0);
        tick();
        bus.m_gnt = 0;
        #1;
        chk("t6 idle m_req", bus.m_req, 0);
        bus.d_req = 1; bus.d_wen = 0; bus.d_addr = 39'h3000;
        tick();
        chk("t6 m_req", bus.m_req, 1);
        chk("t6 rtype", bus.m_rtype, 1);
        chk("t6 wen", bus.m_wen, 0);
        tick();
        bus.m_gnt = 1;
        #1;
        chk("t6 d_gnt", bus.d_gnt, 1);
        tick();
        bus.m_gnt = 0; bus.m_err = 1; bus.m_rdata = 64'hFEED; bus.d_req = 0;
        #1;
        chk("t6 d_err", bus.d_err, 1);
        chk("t6 d_rdata", bus.d_rdata, 64'hFEED);
        chk("t6 i_err", bus.i_err, 1);
        chk("t6 after d_gnt", bus.d_gnt, 0);
        tick();
        bus.m_err = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
